// File: rtl/alu.sv
// ============================================================================
// Module   : alu
// Brief    : 32-bit datapath ALU with a registered 64-bit result. Covers
//            add/sub, logic, shifts and rotates, a radix-4 Booth multiplier,
//            and a signed restoring divider. All of these are combinational,
//            so every result is ready one clock after its inputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 IncPC,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [4:0]           opcode,
  output logic [2*WIDTH-1:0]   result
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [2*WIDTH-1:0] result_q;
  logic [2*WIDTH-1:0] result_d;

  // Only the low 5 bits of B set the shift or rotate distance.
  logic [4:0]         sh_amt;
  logic [2*WIDTH-1:0] a_dbl;
  logic [2*WIDTH-1:0] ror_full;
  logic [2*WIDTH-1:0] rol_full;

  assign sh_amt   = B[4:0];
  assign a_dbl    = {A, A};
  assign ror_full = a_dbl >> sh_amt;
  assign rol_full = a_dbl << sh_amt;

  // Radix-4 Booth multiplier. Each group of three multiplier bits picks a
  // partial product from {0, +-A, +-2A}, which is then weighted by 4^i.
  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] pp;
  logic [WIDTH:0]     b_ext;
  logic [2:0]         grp;

  always_comb begin
    a_ext   = {{WIDTH{A[WIDTH-1]}}, A};
    b_ext   = {B, 1'b0};
    mul_acc = '0;
    pp      = '0;
    grp     = '0;
    for (int i = 0; i < WIDTH / 2; i++) begin
      grp = b_ext[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      mul_acc = mul_acc + (pp << (2 * i));
    end
  end

  // Signed divide: a restoring array works on the operand magnitudes, and
  // signs are applied afterwards. The quotient's sign is sign(A) xor sign(B).
  // The remainder takes the dividend's sign. Dividing by zero gives all-ones
  // and passes A through.
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH:0]   r_part;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;

  always_comb begin
    a_mag  = A[WIDTH-1] ? -A : A;
    b_mag  = B[WIDTH-1] ? -B : B;
    r_part = '0;
    q_mag  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      r_part = {r_part[WIDTH-1:0], a_mag[i]};
      if (r_part >= {1'b0, b_mag}) begin
        r_part   = r_part - {1'b0, b_mag};
        q_mag[i] = 1'b1;
      end
    end
    div_quot = (A[WIDTH-1] ^ B[WIDTH-1]) ? -q_mag : q_mag;
    div_rem  = A[WIDTH-1] ? -r_part[WIDTH-1:0] : r_part[WIDTH-1:0];
    if (B == '0) begin
      div_quot = '1;
      div_rem  = A;
    end
  end

  // Select the next result. IncPC overrides the opcode.
  always_comb begin
    result_d = '0;
    if (IncPC) begin
      result_d[WIDTH-1:0] = A + 1'b1;
    end else begin
      case (opcode)
        OP_ADD:  result_d[WIDTH-1:0] = A + B;
        OP_SUB:  result_d[WIDTH-1:0] = A - B;
        OP_AND:  result_d[WIDTH-1:0] = A & B;
        OP_OR:   result_d[WIDTH-1:0] = A | B;
        OP_SHR:  result_d[WIDTH-1:0] = A >> sh_amt;
        OP_SHRA: result_d[WIDTH-1:0] = $signed(A) >>> sh_amt;
        OP_SHL:  result_d[WIDTH-1:0] = A << sh_amt;
        OP_ROR:  result_d[WIDTH-1:0] = ror_full[WIDTH-1:0];
        OP_ROL:  result_d[WIDTH-1:0] = rol_full[2*WIDTH-1:WIDTH];
        OP_MUL:  result_d            = mul_acc;
        OP_DIV:  result_d            = {div_rem, div_quot};
        OP_NEG:  result_d[WIDTH-1:0] = -A;
        OP_NOT:  result_d[WIDTH-1:0] = ~A;
        default: result_d            = '0;
      endcase
    end
  end

  // Result register. clr clears it asynchronously and drops any pending op.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module   : tb_alu
// Brief    : Self-checking bench for alu. Expected results are queued when
//            stimulus is applied, then popped and compared once the result
//            register has updated.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu;

  logic        clk;
  logic        clr;
  logic        IncPC;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  opcode;
  logic [63:0] result;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic        inc;
    logic [63:0] exp;
    string       name;
  } vec_t;

  alu #(.WIDTH(32)) dut (
    .clk    (clk),
    .clr    (clr),
    .IncPC  (IncPC),
    .A      (A),
    .B      (B),
    .opcode (opcode),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one vector's inputs and queue its expected result.
  task automatic apply(input vec_t v);
    A      = v.a;
    B      = v.b;
    opcode = v.op;
    IncPC  = v.inc;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] op, input logic inc,
                              input logic [63:0] exp, input string name);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.inc = inc; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic test_reset();
    logic [63:0] e;
    string       nm;
    clr = 1'b0; IncPC = 1'b0; A = 32'h1234; B = 32'h5678; opcode = 5'b00011;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (result !== 64'h0) begin
      errors++; $display("FAIL reset_hold: got %h expected %h", result, 64'h0);
    end
    clr = 1'b1;
    apply(mk(32'd5, 32'd10, 5'b00011, 1'b0, 64'd15, "reset_release_add"));
    @(posedge clk); #1;
    e = exp_q.pop_front(); nm = name_q.pop_front();
    checks++;
    if (result !== e) begin
      errors++; $display("FAIL %s: got %h expected %h", nm, result, e);
    end
    // Assert clr between clock edges. The register must clear with no edge.
    #2 clr = 1'b0;
    #1;
    checks++;
    if (result !== 64'h0) begin
      errors++; $display("FAIL reset_async: got %h expected %h", result, 64'h0);
    end
    @(posedge clk); #1;
    clr = 1'b1;
  endtask

  task automatic test_logic();
    vec_t v[$];
    logic [63:0] e;
    string nm;
    v.push_back(mk(32'd5, 32'd4, 5'b00101, 1'b0, 64'd4, "and"));
    v.push_back(mk(32'd6, 32'd3, 5'b00110, 1'b0, 64'd7, "or"));
    v.push_back(mk(32'd5, 32'd0, 5'b10010, 1'b0, 64'h00000000_FFFFFFFA, "not"));
    v.push_back(mk(32'd5, 32'd0, 5'b10001, 1'b0, 64'h00000000_FFFFFFFB, "neg"));
    v.push_back(mk(32'h80000000, 32'd0, 5'b10001, 1'b0, 64'h00000000_80000000, "neg_min"));
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (result !== e) begin
        errors++; $display("FAIL %s: got %h expected %h", nm, result, e);
      end
    end
  endtask

  task automatic test_addsub();
    vec_t v[$];
    logic [63:0] e;
    string nm;
    v.push_back(mk(-32'sd5, 32'd8, 5'b00011, 1'b0, 64'd3, "add_neg_pos"));
    v.push_back(mk(-32'sd55, -32'sd10, 5'b00011, 1'b0, 64'h00000000_FFFFFFBF, "add_neg_neg"));
    v.push_back(mk(32'd75, 32'd11, 5'b00100, 1'b0, 64'd64, "sub"));
    v.push_back(mk(32'hFFFFFFFF, 32'd0, 5'b00011, 1'b1, 64'd0, "incpc_wrap"));
    v.push_back(mk(32'd5, 32'd9, 5'b01111, 1'b1, 64'd6, "incpc_priority"));
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (result !== e) begin
        errors++; $display("FAIL %s: got %h expected %h", nm, result, e);
      end
    end
  endtask

  task automatic test_mul();
    vec_t v[$];
    logic [63:0] e;
    string nm;
    v.push_back(mk(32'd723, 32'd19, 5'b01111, 1'b0, 64'h00000000_000035A9, "mul_pos"));
    v.push_back(mk(-32'sd723, 32'd19, 5'b01111, 1'b0, 64'hFFFFFFFF_FFFFCA57, "mul_neg_a"));
    v.push_back(mk(-32'sd750, 32'd10, 5'b01111, 1'b0, 64'hFFFFFFFF_FFFFE2B4, "mul_neg_b"));
    v.push_back(mk(32'h80000000, 32'h80000000, 5'b01111, 1'b0, 64'h40000000_00000000, "mul_min_min"));
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (result !== e) begin
        errors++; $display("FAIL %s: got %h expected %h", nm, result, e);
      end
    end
  endtask

  task automatic test_div();
    vec_t v[$];
    logic [63:0] e;
    string nm;
    v.push_back(mk(32'd780, 32'd40, 5'b10000, 1'b0, {32'd20, 32'd19}, "div_pos"));
    v.push_back(mk(-32'sd780, 32'd40, 5'b10000, 1'b0, 64'hFFFFFFEC_FFFFFFED, "div_neg"));
    v.push_back(mk(32'd7, 32'd0, 5'b10000, 1'b0, 64'h00000007_FFFFFFFF, "div_by_zero"));
    v.push_back(mk(32'h80000000, 32'hFFFFFFFF, 5'b10000, 1'b0, 64'h00000000_80000000, "div_overflow"));
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (result !== e) begin
        errors++; $display("FAIL %s: got %h expected %h", nm, result, e);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[$];
    logic [63:0] e;
    string nm;
    v.push_back(mk(32'd7, 32'd2, 5'b00111, 1'b0, 64'd1, "shr"));
    v.push_back(mk(-32'sd10, 32'd2, 5'b01000, 1'b0, 64'h00000000_FFFFFFFD, "shra"));
    v.push_back(mk(32'hEE, 32'd4, 5'b01001, 1'b0, 64'hEE0, "shl"));
    v.push_back(mk(32'h17, 32'd2, 5'b01010, 1'b0, 64'h00000000_C0000005, "ror"));
    v.push_back(mk(32'h0E, 32'd4, 5'b01011, 1'b0, 64'hE0, "rol"));
    v.push_back(mk(32'h1234ABCD, 32'hFFFFFFE0, 5'b01001, 1'b0, 64'h1234ABCD, "shl_by0_hi_ignored"));
    v.push_back(mk(32'h80000001, 32'd0, 5'b01010, 1'b0, 64'h80000001, "ror_by0"));
    v.push_back(mk(32'h80000001, 32'd32, 5'b01011, 1'b0, 64'h80000001, "rol_by32_is0"));
    v.push_back(mk(32'h80000000, 32'd31, 5'b01000, 1'b0, 64'h00000000_FFFFFFFF, "shra_31"));
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (result !== e) begin
        errors++; $display("FAIL %s: got %h expected %h", nm, result, e);
      end
    end
  endtask

  task automatic test_misc();
    vec_t v[$];
    logic [63:0] e;
    string nm;
    v.push_back(mk(32'd5, 32'd6, 5'b00000, 1'b0, 64'd0, "op_unused_00000"));
    v.push_back(mk(32'd5, 32'd6, 5'b11111, 1'b0, 64'd0, "op_unused_11111"));
    v.push_back(mk(32'd5, 32'd6, 5'b01100, 1'b0, 64'd0, "op_unused_01100"));
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (result !== e) begin
        errors++; $display("FAIL %s: got %h expected %h", nm, result, e);
      end
    end
    // Reset asserted while an op is set up must discard that op.
    apply(mk(32'd723, 32'd19, 5'b01111, 1'b0, 64'h0, "mid_reset_discard"));
    #1 clr = 1'b0;
    @(posedge clk); #1;
    e = exp_q.pop_front(); nm = name_q.pop_front();
    checks++;
    if (result !== e) begin
      errors++; $display("FAIL %s: got %h expected %h", nm, result, e);
    end
    clr = 1'b1;
  endtask

  task automatic test_back_to_back();
    vec_t        v;
    logic [63:0] e;
    string       nm;
    logic [31:0] a, b, q, r;
    logic [63:0] p;
    int          k;
    for (int n = 0; n < 40; n++) begin
      a = $urandom();
      b = $urandom();
      if (n % 3 == 0) b = b >> ($urandom_range(0, 31));
      if (b == 32'h0) b = 32'd3;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd2;
      k = n % 4;
      case (k)
        0: begin
          v = mk(a, b, 5'b00011, 1'b0, {32'h0, a + b}, "b2b_add");
        end
        1: begin
          v = mk(a, b, 5'b00100, 1'b0, {32'h0, a - b}, "b2b_sub");
        end
        2: begin
          p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
          v = mk(a, b, 5'b01111, 1'b0, p, "b2b_mul");
        end
        default: begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          v = mk(a, b, 5'b10000, 1'b0, {r, q}, "b2b_div");
        end
      endcase
      apply(v);
      @(posedge clk); #1;
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (result !== e) begin
        errors++;
        $display("FAIL %s: A=%h B=%h got %h expected %h", nm, v.a, v.b, result, e);
      end
    end
  endtask

  initial begin
    clr = 1'b0; IncPC = 1'b0; A = '0; B = '0; opcode = '0;
    test_reset();
    test_logic();
    test_addsub();
    test_mul();
    test_div();
    test_shift();
    test_misc();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
